// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage buffer: a DEPTH-entry circular FIFO with a valid/ready handshake and a synchronous flush.
// Defining PIPE_STAGE_PERF_EN adds the saturating stall_cycles counter output.
module pipe_stage_buf #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 1,
    parameter bit READY_PASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             has_space;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A transfer happens on an edge where valid and ready are both high and
    // flush is low; valid never waits on ready, and ready may depend on
    // out_ready only when READY_PASS lets a same-cycle pop make room.
    always_comb begin
        has_space = (count_q != FULL_CNT);
        in_ready  = has_space | (READY_PASS & out_ready);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        count     = count_q;
    end

    // Head entry is a pure register mux, so out_data has no path from in_data.
    always_comb begin
        out_data = mem_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (rd_ptr_q == PTR_W'(i)) out_data = mem_q[i];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr_q == PTR_W'(i))) mem_d[i] = in_data;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Only reset clears the counter; flush cycles are neither counted nor clearing.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH/READY_PASS = 1/1, 3/1, 2/0) checked against queue models.
// The stall counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           iv   [3];
    logic           ordy [3];
    logic           fl   [3];
    logic [W-1:0]   idat [3];
    logic           ov   [3];
    logic           ir   [3];
    logic [W-1:0]   odat [3];
    logic [0:0]     cnt0;
    logic [1:0]     cnt1;
    logic [1:0]     cnt2;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]    stall0, stall1, stall2;
    logic [31:0]    stall_exp;
`endif

    pipe_stage_buf #(.WIDTH(W), .DEPTH(1), .READY_PASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(odat[0]), .out_ready(ordy[0]), .flush(fl[0]), .count(cnt0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall0)
`endif
    );

    pipe_stage_buf #(.WIDTH(W), .DEPTH(3), .READY_PASS(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(odat[1]), .out_ready(ordy[1]), .flush(fl[1]), .count(cnt1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall1)
`endif
    );

    pipe_stage_buf #(.WIDTH(W), .DEPTH(2), .READY_PASS(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(idat[2]), .in_ready(ir[2]),
        .out_valid(ov[2]), .out_data(odat[2]), .out_ready(ordy[2]), .flush(fl[2]), .count(cnt2)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall2)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_stable = 1'b0;
    bit acc [3];

    // Reference model: one queue of accepted payloads per instance.
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic [W-1:0] q2 [$];

    function automatic int dep_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit rp_of(input int k);
        return (k != 2);
    endfunction

    function automatic int msize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [W-1:0] mhead(input int k);
        if (msize(k) == 0) return '0;
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic bit exp_ready(input int k);
        return (msize(k) < dep_of(k)) || (rp_of(k) && ordy[k]);
    endfunction

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic q_clear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic q_pop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic q_push(input int k, input logic [W-1:0] d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    // Advance one clock: decide each instance's transfers from the model and current inputs.
    task automatic tick();
        bit           psh [3];
        bit           pp  [3];
        bit           f   [3];
        logic [W-1:0] d   [3];
        for (int k = 0; k < 3; k++) begin
            f[k]   = fl[k];
            psh[k] = iv[k] && exp_ready(k) && !fl[k];
            pp[k]  = (msize(k) > 0) && ordy[k] && !fl[k];
            d[k]   = idat[k];
        end
`ifdef PIPE_STAGE_PERF_EN
        if (iv[0] && !exp_ready(0) && !fl[0] && stall_exp != 32'hFFFF_FFFF) stall_exp++;
`endif
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            acc[k] = psh[k];
            if (f[k]) q_clear(k);
            else begin
                if (pp[k])  q_pop(k);
                if (psh[k]) q_push(k, d[k]);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; idat[k] = '0;
        end
    endtask

    // Upstream must hold valid/data while not ready.
    logic         pv [3];
    logic         pr [3];
    logic [W-1:0] pd [3];
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (chk_stable && pv[k] === 1'b1 && pr[k] === 1'b0) begin
                checks++;
                if (iv[k] !== 1'b1 || idat[k] !== pd[k]) begin
                    errors++;
                    $display("FAIL upstream_hold[%0d]: valid=%b data=%0h, required valid=1 data=%0h",
                             k, iv[k], idat[k], pd[k]);
                end
            end
            pv[k] <= iv[k];
            pr[k] <= ir[k];
            pd[k] <= idat[k];
        end
    end

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_of(k) !== 0) begin errors++; $display("FAIL reset_count[%0d]: got %0d want 0", k, cnt_of(k)); end
            checks++;
            if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
            checks++;
            if (ir[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]); end
            checks++;
            if (odat[k] !== '0) begin errors++; $display("FAIL reset_out_data[%0d]: got %0h want 0", k, odat[k]); end
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (stall0 !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall0); end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [W-1:0] vals [3];
        vals[0] = 8'h0A; vals[1] = 8'h0B; vals[2] = 8'h0C;
        ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv[0]   = (i < 3);
            idat[0] = (i < 3) ? vals[i] : 8'h00;
            #1;
            checks++;
            if (ir[0] !== 1'b1) begin errors++; $display("FAIL stream_in_ready cycle %0d: got %b want 1", i, ir[0]); end
            if (i > 0) begin
                checks++;
                if (ov[0] !== 1'b1 || odat[0] !== vals[i-1]) begin
                    errors++;
                    $display("FAIL stream_out cycle %0d: got v=%b d=%0h want v=1 d=%0h", i, ov[0], odat[0], vals[i-1]);
                end
            end
            tick();
        end
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL stream_drained: got out_valid %b want 0", ov[0]); end
        idle_inputs();
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] got [$];
        int idx  = 0;
        int hold = 0;
        for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
            iv[1]   = (idx < 4);
            idat[1] = W'(idx + 1);
            if (idx == 3 && hold >= 2) ordy[1] = 1'b1;
            #1;
            if (idx == 3 && !ordy[1]) begin
                hold++;
                checks++;
                if (cnt1 !== 2'd3 || ir[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_full: got count=%0d ready=%b want count=3 ready=0", cnt1, ir[1]);
                end
            end
            checks++;
            if (ir[1] !== exp_ready(1)) begin errors++; $display("FAIL fill_in_ready: got %b want %b", ir[1], exp_ready(1)); end
            if (msize(1) > 0) begin
                checks++;
                if (ov[1] !== 1'b1 || odat[1] !== mhead(1)) begin
                    errors++;
                    $display("FAIL fill_head: got v=%b d=%0h want v=1 d=%0h", ov[1], odat[1], mhead(1));
                end
                if (ordy[1]) got.push_back(odat[1]);
            end
            tick();
            if (acc[1]) idx++;
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL drain_count: got %0d items want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== W'(i + 1)) begin errors++; $display("FAIL drain_order[%0d]: got %0h want %0h", i, got[i], i + 1); end
            end
        end
        checks++;
        if (cnt1 !== 2'd0 || ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got count=%0d valid=%b want 0/0", cnt1, ov[1]);
        end
        idle_inputs();
    endtask

    task automatic test_full_pass();
        // READY_PASS=1 instance: full, streaming through.
        for (int i = 0; i < 3; i++) begin
            iv[1] = 1'b1; idat[1] = W'($urandom_range(0, 255));
            tick();
        end
        ordy[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idat[1] = W'($urandom_range(0, 255));
            #1;
            checks++;
            if (cnt1 !== 2'd3 || ir[1] !== 1'b1) begin
                errors++;
                $display("FAIL pass_full: got count=%0d ready=%b want count=3 ready=1", cnt1, ir[1]);
            end
            checks++;
            if (odat[1] !== mhead(1)) begin errors++; $display("FAIL pass_order: got %0h want %0h", odat[1], mhead(1)); end
            tick();
        end
        iv[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ov[1] !== 1'b1 || odat[1] !== mhead(1)) begin
                errors++;
                $display("FAIL pass_drain: got v=%b d=%0h want v=1 d=%0h", ov[1], odat[1], mhead(1));
            end
            tick();
        end
        idle_inputs();

        // READY_PASS=0 instance: a full buffer never accepts.
        for (int i = 0; i < 2; i++) begin
            iv[2] = 1'b1; idat[2] = W'($urandom_range(0, 255));
            tick();
        end
        ordy[2] = 1'b1;
        idat[2] = W'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (ir[2] !== (msize(2) < 2)) begin
                errors++;
                $display("FAIL nopass_ready: got %b want %b at count %0d", ir[2], msize(2) < 2, msize(2));
            end
            checks++;
            if (cnt2 !== 2'(msize(2)) || odat[2] !== mhead(2)) begin
                errors++;
                $display("FAIL nopass_state: got count=%0d d=%0h want count=%0d d=%0h", cnt2, odat[2], msize(2), mhead(2));
            end
            tick();
            if (acc[2]) idat[2] = W'($urandom_range(0, 255));
        end
        iv[2] = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            iv[1] = 1'b1; idat[1] = W'(8'h30 + i);
            tick();
        end
        iv[1] = 1'b1; idat[1] = 8'hEE; fl[1] = 1'b1; ordy[1] = 1'b1;
        tick();
        iv[1] = 1'b0; fl[1] = 1'b0;
        #1;
        checks++;
        if (cnt1 !== 2'd0 || ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got count=%0d valid=%b ready=%b want 0/0/1", cnt1, ov[1], ir[1]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ov[1] !== 1'b0) begin errors++; $display("FAIL flush_ghost: got valid=%b data=%0h want valid=0", ov[1], odat[1]); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        iv[1] = 1'b1; idat[1] = 8'h11;
        tick();
        idat[1] = 8'h22;
        tick();
        iv[1] = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (ov[1] !== 1'b0 || odat[1] !== '0 || cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%0h count=%0d want 0/0/0", ov[1], odat[1], cnt1);
        end
        for (int k = 0; k < 3; k++) q_clear(k);
`ifdef PIPE_STAGE_PERF_EN
        stall_exp = '0;
`endif
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b1; idat[1] = 8'h55; ordy[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        #1;
        checks++;
        if (ov[1] !== 1'b1 || odat[1] !== 8'h55) begin
            errors++;
            $display("FAIL reset_first_push: got v=%b d=%0h want v=1 d=55", ov[1], odat[1]);
        end
        tick();
        idle_inputs();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        iv[0] = 1'b1; idat[0] = 8'h77;
        for (int i = 0; i < 10; i++) tick();
        iv[0] = 1'b0;
        #1;
        checks++;
        if (stall0 !== 32'd9 || stall0 !== stall_exp) begin
            errors++;
            $display("FAIL stall_count: got %0d want 9 (model %0d)", stall0, stall_exp);
        end
        iv[0] = 1'b1; fl[0] = 1'b1;
        tick();
        iv[0] = 1'b0; fl[0] = 1'b0;
        #1;
        checks++;
        if (stall0 !== 32'd9) begin errors++; $display("FAIL stall_after_flush: got %0d want 9", stall0); end
        idle_inputs();
        tick();
    endtask
`endif

    task automatic test_random();
        bit hold [3];
        for (int k = 0; k < 3; k++) hold[k] = 1'b0;
        chk_stable = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (!hold[k]) begin
                    iv[k]   = ($urandom_range(0, 3) != 0);
                    idat[k] = W'($urandom_range(0, 255));
                end
                ordy[k] = ($urandom_range(0, 2) != 0);
                fl[k]   = ($urandom_range(0, 29) == 0);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cnt_of(k) !== msize(k) || ov[k] !== (msize(k) > 0) || ir[k] !== exp_ready(k)) begin
                    errors++;
                    $display("FAIL rand_ctrl[%0d] cyc %0d: got count=%0d valid=%b ready=%b want %0d/%b/%b",
                             k, cyc, cnt_of(k), ov[k], ir[k], msize(k), msize(k) > 0, exp_ready(k));
                end
                if (msize(k) > 0) begin
                    checks++;
                    if (odat[k] !== mhead(k)) begin
                        errors++;
                        $display("FAIL rand_data[%0d] cyc %0d: got %0h want %0h", k, cyc, odat[k], mhead(k));
                    end
                end
            end
            tick();
            for (int k = 0; k < 3; k++) hold[k] = iv[k] && !acc[k];
        end
        idle_inputs();
        tick();
        chk_stable = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (stall0 !== stall_exp) begin errors++; $display("FAIL rand_stall: got %0d want %0d", stall0, stall_exp); end
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
`ifdef PIPE_STAGE_PERF_EN
        stall_exp = '0;
`endif
        #12;
        test_reset();
        test_stream();
        test_fill_drain();
        test_full_pass();
        test_flush();
        test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage buffer with valid/ready handshake. It replaces the fixed single-entry inter-stage registers (IF/ID/EX/LSU/WB) with one generic block. The block has configurable payload width, an entry count of 1..N, an optional ready pass-through path and a synchronous flush. The owning stage packs its control, PC/inst and data fields into one `in_data` vector, and the next stage unpacks `out_data`.

## Interface
Parameters:
- `WIDTH`, default 64: payload bits per entry (≥1).
- `DEPTH`, default 1: number of entries (≥1; non-power-of-two allowed).
- `READY_PASS`, default 1: 1 lets a same-cycle pop free space for a push when full; 0 makes `in_ready` depend only on registered state.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: upstream holds a valid payload.
- `in_data`, in, WIDTH: upstream payload.
- `in_ready`, out, 1: stage accepts this cycle (allow-in).
- `out_valid`, out, 1: head entry is valid.
- `out_data`, out, WIDTH: head entry payload.
- `out_ready`, in, 1: downstream consumes head this cycle.
- `flush`, in, 1: synchronous discard of all entries.
- `count`, out, $clog2(DEPTH+1): current occupancy.
- `stall_cycles`, out, 32: present only with PIPE_STAGE_PERF_EN.

## Operation
- Storage is a circular buffer of DEPTH entries with a write pointer, a read pointer and `count`.
- Pointers advance by 1 and wrap from DEPTH-1 to 0 for any DEPTH.
- `push = in_valid & in_ready & ~flush`.
- `pop = out_valid & out_ready & ~flush`.
- `out_valid = (count != 0)`.
- `out_data = mem[rd_ptr]`, driven directly from a register with no combinational path from `in_data`.
- `in_ready`:
  - READY_PASS=1: `(count < DEPTH) | out_ready`.
  - READY_PASS=0: `(count < DEPTH)`.
  - With DEPTH=1 and READY_PASS=1 this reduces to `~out_valid | out_ready`, i.e. classic allow-in.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: hold.
- Flush: `count`, `wr_ptr` and `rd_ptr` go to 0. `in_valid` and `out_ready` are ignored in the flush cycle. Flush has priority over push and pop.
- Entry contents are written only on push. Stale contents behind `rd_ptr` are don't-care, but `out_data` must never change while `out_valid=1` and no pop occurs.
- `in_data` is never sampled when `push=0`.

## Timing
- Reset (`rst`=0, asynchronous) puts the block in this state:
  - `count` = 0, `out_valid` = 0, `in_ready` = 1.
  - All entries = 0, so `out_data` = 0.
  - Both pointers = 0; `stall_cycles` = 0.
- Reset asserted mid-transfer drops all entries immediately, with no partial handshake completed.
- Latency: a payload pushed at edge N is visible with `out_valid=1` after edge N; there is no empty bypass.
- Throughput: 1 transfer/cycle sustained for any DEPTH while `out_ready=1`.
  - Exception: READY_PASS=0 with DEPTH=1 gives at most 1 transfer per 2 cycles.
- Full with READY_PASS=1 and `out_ready=1`: push and pop occur in the same cycle and `count` stays DEPTH.
- Empty with `out_ready=1`: no pop and no underflow.
- Flush with push in the same cycle: the push is discarded and `count` = 0 after the edge.
- Upstream must hold `in_valid`/`in_data` stable until `in_ready`. This is not checked in RTL; the bench asserts it.

## Configuration
- `PIPE_STAGE_PERF_EN` defined: adds output `stall_cycles`. It increments by 1 on each cycle with `in_valid & ~in_ready & ~flush`. It saturates at 0xFFFF_FFFF, is cleared only by reset, and is not affected by flush.
- Not defined: the port and the counter logic are absent. Handshake behaviour is identical.

## Test plan
- DEPTH=1, READY_PASS=1, `out_ready`=1 held, push 0xA, 0xB, 0xC on consecutive cycles → `out_data` = 0xA, 0xB, 0xC on the 3 following cycles; `in_ready` stays 1.
- DEPTH=3, `out_ready`=0, push 4 items → `count` = 3, `in_ready`=0 after the 3rd push, 4th held. Then set `out_ready`=1 → pops in order 1, 2, 3, 4, and the pointers wrap correctly.
- DEPTH=2 full, READY_PASS=1, `in_valid`=1, `out_ready`=1 for 5 cycles → `count` remains 2 and output order is preserved. With READY_PASS=0 → `in_ready`=0 on every full cycle.
- DEPTH=4 with 3 entries, `flush`=1 plus a simultaneous push → next cycle `count` = 0, `out_valid`=0, `in_ready`=1, and the pushed data never appears.
- Assert `rst`=0 asynchronously mid-stream with 2 entries held → `out_valid`=0 and `out_data`=0 before the next clock edge; after release the first new push is output first.
- With PIPE_STAGE_PERF_EN, DEPTH=1, `out_ready`=0, `in_valid`=1 for 10 cycles → `stall_cycles` = 9. A flush does not clear it.
